mc_request_responder: RTL and testbench

- Synthesizable responder model for the memory-controller front-end request interface (in_valid / in_request_type / in_request_address / in_request_data, answered by out_busy / write_done / read_done / data_out).
- Stands in for the full controller plus DDR5 memory when bringing up and self-checking traffic generators.
- Buffers requests in an in-order FIFO, services them against a small on-chip array, and returns read data after a fixed latency.

---
 rtl/mc_request_responder_if.sv | 27 ++
 rtl/mc_request_responder.sv | 126 ++++++++++++
 tb/tb_mc_request_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_request_responder_if.sv
// Request/response bundle between a traffic generator and the memory-controller responder.
// The requester drives requests and stall; the responder returns backpressure and completions.
interface mc_request_responder_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 30
);
    logic                     in_valid;
    logic                     in_request_type;
    logic [ADDRESS_WIDTH-1:0] in_request_address;
    logic [DATA_WIDTH-1:0]    in_request_data;
    logic                     stall;
    logic                     out_busy;
    logic                     write_done;
    logic                     read_done;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     overflow_err;

    modport master (
        output in_valid, in_request_type, in_request_address, in_request_data, stall,
        input  out_busy, write_done, read_done, data_out, overflow_err
    );

    modport slave (
        input  in_valid, in_request_type, in_request_address, in_request_data, stall,
        output out_busy, write_done, read_done, data_out, overflow_err
    );
endinterface

// File: rtl/mc_request_responder.sv
// Responder model for the memory-controller front end: in-order request FIFO, small on-chip
// array, and a fixed-latency read return pipeline.
module mc_request_responder #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 30,
    parameter int MEM_AW        = 10,
    parameter int FIFO_DEPTH    = 8,
    parameter int READ_LATENCY  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mc_request_responder_if.slave bus
);

    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam logic [PW:0] FULL     = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] BUSY_LVL = (PW+1)'(FIFO_DEPTH - 1);

    // Only the array index is kept; upper address bits alias by design.
    typedef struct packed {
        logic                  wr;
        logic [MEM_AW-1:0]     idx;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t                  r_fifo [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem  [MEM_DEPTH];

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;
    logic                  r_busy;
    logic                  r_wdone;
    logic                  r_ovf;
    logic [READ_LATENCY:1] r_vld_pipe;
    logic [DATA_WIDTH-1:0] r_dat_pipe [READ_LATENCY:1];

    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_pop;
    logic                  w_wr_pop;
    req_t                  w_head;
    req_t                  w_new;
    logic [PW:0]           w_count_nxt;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused_addr;

    assign w_unused_addr = ^bus.in_request_address[ADDRESS_WIDTH-1:MEM_AW];

    // Pop looks at the pre-push count, so an entry never falls through in its arrival cycle;
    // a pop frees a slot for a same-cycle push even when full.
    assign w_pop    = (r_count != '0) && !bus.stall;
    assign w_push   = bus.in_valid && ((r_count != FULL) || w_pop);
    assign w_head   = r_fifo[r_rd_ptr];
    assign w_rd_pop = w_pop && !w_head.wr;
    assign w_wr_pop = w_pop &&  w_head.wr;
    assign w_rd_data = r_mem[w_head.idx];

    assign w_new.wr   = bus.in_request_type;
    assign w_new.idx  = bus.in_request_address[MEM_AW-1:0];
    assign w_new.data = bus.in_request_data;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + (PW+1)'(1);
        else if (w_pop && !w_push)
            w_count_nxt = r_count - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_new;
    end

    // A write lands at its pop edge, so a read popped the next cycle already sees it.
    always_ff @(posedge clk) begin
        if (w_wr_pop)
            r_mem[w_head.idx] <= w_head.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_wdone  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt >= BUSY_LVL);
            r_wdone <= w_wr_pop;
            if (bus.in_valid && !w_push)
                r_ovf <= 1'b1;
        end
    end

    // Data is zeroed on entry for empty slots so data_out is 0 whenever read_done is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int i = 1; i <= READ_LATENCY; i++)
                r_dat_pipe[i] <= '0;
        end else begin
            r_vld_pipe[1] <= w_rd_pop;
            r_dat_pipe[1] <= w_rd_pop ? w_rd_data : '0;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_dat_pipe[i] <= r_dat_pipe[i-1];
            end
        end
    end

    assign bus.out_busy     = r_busy;
    assign bus.write_done   = r_wdone;
    assign bus.read_done    = r_vld_pipe[READ_LATENCY];
    assign bus.data_out     = r_dat_pipe[READ_LATENCY];
    assign bus.overflow_err = r_ovf;

endmodule

// File: tb/tb_mc_request_responder.sv
// Bench for mc_request_responder: directed scenarios plus random traffic, all checked every
// cycle against a queue-based model of the request/response rules.
module tb_mc_request_responder;

    localparam int DW    = 16;
    localparam int AW    = 30;
    localparam int MAW   = 10;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_request_responder_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    mc_request_responder #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_AW(MAW),
        .FIFO_DEPTH(DEPTH), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit wr; int idx; logic [DW-1:0] d; } mreq_t;
    typedef struct { int due; logic [DW-1:0] d; bit known; } mrd_t;

    mreq_t         q[$];
    mrd_t          rdq[$];
    logic [DW-1:0] mem[int];
    int            edge_n = 0;
    bit            m_busy, m_wdone, m_rdone, m_ovf, m_dknown;
    logic [DW-1:0] m_dout;

    always @(posedge clk or negedge rst_n) begin : model
        bit    pop, push;
        mreq_t e, n;
        mrd_t  r;
        if (!rst_n) begin
            q.delete();
            rdq.delete();
            m_busy = 0; m_wdone = 0; m_rdone = 0; m_ovf = 0; m_dout = '0; m_dknown = 1;
        end else begin
            edge_n++;
            pop  = (q.size() > 0) && !bus.stall;
            push = bus.in_valid && ((q.size() < DEPTH) || pop);
            if (bus.in_valid && !push) m_ovf = 1;
            m_wdone = 0;
            if (pop) begin
                e = q.pop_front();
                if (e.wr) begin
                    mem[e.idx] = e.d;
                    m_wdone = 1;
                end else begin
                    r.due   = edge_n + LAT - 1;
                    r.known = mem.exists(e.idx);
                    r.d     = r.known ? mem[e.idx] : '0;
                    rdq.push_back(r);
                end
            end
            if (push) begin
                n.wr  = bus.in_request_type;
                n.idx = int'(bus.in_request_address) % (1 << MAW);
                n.d   = bus.in_request_data;
                q.push_back(n);
            end
            m_busy  = (q.size() >= DEPTH - 1);
            m_rdone = 0; m_dout = '0; m_dknown = 1;
            if (rdq.size() > 0 && rdq[0].due == edge_n) begin
                r = rdq.pop_front();
                m_rdone = 1; m_dout = r.d; m_dknown = r.known;
            end
        end
    end

    // ---------------- compare process ----------------
    bit            cmp_en = 0;
    int            n_wd = 0;
    int            n_rd = 0;
    logic [DW-1:0] rd_log[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_busy",     bus.out_busy,     m_busy);
            check("write_done",   bus.write_done,   m_wdone);
            check("read_done",    bus.read_done,    m_rdone);
            check("overflow_err", bus.overflow_err, m_ovf);
            if (m_rdone) begin
                if (m_dknown) check("data_out", bus.data_out, m_dout);
            end else begin
                check("data_out_idle", bus.data_out, 0);
            end
            if (bus.write_done === 1'b1) n_wd++;
            if (bus.read_done === 1'b1) begin
                n_rd++;
                rd_log.push_back(bus.data_out);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #2;
        bus.in_valid = v; bus.in_request_type = wr;
        bus.in_request_address = a; bus.in_request_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        rst_n = 1'b0;
        bus.in_valid = 0;
        repeat (n) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, bus.out_busy, 0);
        check({tag, "_wdone"}, bus.write_done, 0);
        check({tag, "_rdone"}, bus.read_done, 0);
        check({tag, "_data"}, bus.data_out, 0);
        check({tag, "_ovf"}, bus.overflow_err, 0);
    endtask

    initial begin
        int base_wd, base_rd, acc;
        bit b, v, honour;
        bus.in_valid = 0; bus.in_request_type = 0; bus.in_request_address = '0;
        bus.in_request_data = '0; bus.stall = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1;
        check_zero_outputs("reset");

        // three writes then three back-to-back reads
        base_wd = n_wd; rd_log.delete();
        for (int k = 0; k < 3; k++) drive(1, 1, AW'(k), DW'(16'hA0 + k));
        for (int k = 0; k < 3; k++) drive(1, 0, AW'(k), '0);
        idle(12);
        check("t1_nreads", rd_log.size(), 3);
        check("t1_rd0", rd_log[0], 16'hA0);
        check("t1_rd1", rd_log[1], 16'hA1);
        check("t1_rd2", rd_log[2], 16'hA2);
        check("t1_nwrites", n_wd - base_wd, 3);
        check("t1_ovf", bus.overflow_err, 0);

        // stalled fill honouring out_busy (sampled one cycle late)
        base_wd = n_wd; acc = 0;
        bus.stall = 1;
        for (int i = 0; i < 12; i++) begin
            b = bus.out_busy;
            drive(!b, 1, AW'(16 + i), DW'(i));
            if (!b) acc++;
        end
        idle(1);
        check("t2_accepted", acc, 8);
        check("t2_busy", bus.out_busy, 1);
        check("t2_ovf", bus.overflow_err, 0);
        bus.stall = 0;
        idle(15);
        check("t2_nwrites", n_wd - base_wd, 8);

        // stalled fill ignoring out_busy -> overflow
        base_wd = n_wd;
        bus.stall = 1;
        for (int i = 0; i < 10; i++) drive(1, 1, AW'(32 + i), DW'(16'h100 + i));
        idle(1);
        check("t3_ovf_set", bus.overflow_err, 1);
        bus.stall = 0;
        idle(15);
        check("t3_nwrites", n_wd - base_wd, 8);
        check("t3_ovf_sticky", bus.overflow_err, 1);
        do_reset(2);
        check("t3_ovf_cleared", bus.overflow_err, 0);

        // address aliasing through the array index width
        rd_log.delete();
        drive(1, 1, 30'h400, 16'h1234);
        drive(1, 0, 30'h000, '0);
        idle(10);
        check("t4_nreads", rd_log.size(), 1);
        check("t4_alias", rd_log[0], 16'h1234);

        // write immediately followed by read of the same index
        rd_log.delete();
        drive(1, 1, 30'd5, 16'h0055);
        drive(1, 0, 30'd5, '0);
        idle(10);
        check("t5_nreads", rd_log.size(), 1);
        check("t5_raw", rd_log[0], 16'h0055);

        // reset while a read is in flight
        base_rd = n_rd;
        drive(1, 0, 30'd3, '0);
        drive(0, 0, '0, '0);
        repeat (2) @(posedge clk);
        do_reset(2);
        idle(10);
        check("t6_no_read", n_rd - base_rd, 0);
        check_zero_outputs("t6");

        // random traffic
        honour = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) honour = ($urandom % 4) != 0;
            b = bus.out_busy;
            v = ($urandom % 3) != 0;
            if (honour && b) v = 0;
            drive(v, 1'($urandom), {AW'($urandom % 64) << 4} | AW'($urandom % 16), DW'($urandom));
            bus.stall = ($urandom % 4) == 0;
            if ($urandom % 700 == 0) do_reset(2);
        end
        bus.stall = 0;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
